// File: rtl/buzzer_sched.sv
// -----------------------------------------------------------------------------
// buzzer_sched
//
// Arbitrates the board's single square-wave buzzer between three requesters
// (alarm melody, hourly chime, key click) and sequences each of them. Drives the
// tone generator with an enable and a half-period divider, and steps a 64-entry
// combinational melody ROM while the alarm plays.
//
// Optional feature macro: BUZZER_CLICK_EN
//   defined   : key_click source and the CLICK state are built.
//   undefined : key_click is ignored, CLICK state and CLICK_DIV logic are absent,
//               src never reports 1.
//
// Ports
//   clk        in   system clock (24 MHz)
//   rst_n      in   asynchronous active-low reset
//   alarm_req  in   one-cycle pulse: alarm time reached
//   chime_req  in   one-cycle pulse: hour rollover
//   key_click  in   one-cycle pulse: debounced key press
//   stop       in   level or pulse: cancel a running alarm
//   song_div   in   [16:0] half-period for song_idx from the melody ROM
//   song_idx   out  [5:0]  melody ROM address (0 outside ALARM)
//   tone_en    out  tone generator enable
//   tone_div   out  [16:0] half-period count for the tone generator
//   src        out  [1:0]  active source: 0 none, 1 click, 2 chime, 3 alarm
//   busy       out  scheduler not idle
//   dbg_state  out  [2:0]  current FSM state encoding
//
// Request semantics: there is no handshake. A request pulse is sampled on the
// rising clk edge; it is either accepted (state changes on that edge) or dropped
// when a source of equal or higher priority is active. Nothing is queued.
// Priority is alarm > chime > click; a higher source preempts a lower one at
// once, clearing the tick counter and the beep/pass counters.
//
// Timing: state and song_idx change on the edge that samples the request.
// tone_en/tone_div/src/busy are registered from the state (and song_div), so
// they follow the state by one cycle.
// -----------------------------------------------------------------------------
module buzzer_sched #(
  parameter int unsigned NOTE_TICKS   = 6000000,
  parameter int unsigned CLICK_TICKS  = 1200000,
  parameter int unsigned ALARM_REPEAT = 3,
  parameter logic [16:0] CHIME_DIV    = 17'd11466,
  parameter logic [16:0] CLICK_DIV    = 17'd5454
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alarm_req,
  input  logic        chime_req,
  input  logic        key_click,
  input  logic        stop,
  input  logic [16:0] song_div,
  output logic [5:0]  song_idx,
  output logic        tone_en,
  output logic [16:0] tone_div,
  output logic [1:0]  src,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic [23:0] NOTE_LAST = 24'(NOTE_TICKS - 1);
  localparam logic [3:0]  REPEAT_N  = 4'(ALARM_REPEAT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
`ifdef BUZZER_CLICK_EN
    S_CLICK     = 3'd1,
`endif
    S_CHIME_ON  = 3'd2,
    S_CHIME_GAP = 3'd3,
    S_ALARM     = 3'd4,
    S_ALARM_GAP = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] tick_q, tick_d;
  logic [1:0]  beep_q, beep_d;   // chime beep count; reused as gap quarter count in ALARM_GAP
  logic [3:0]  pass_q, pass_d;
  logic [5:0]  idx_q, idx_d;

  logic        tone_en_q, tone_en_d;
  logic [16:0] tone_div_q, tone_div_d;
  logic [1:0]  src_q, src_d;
  logic        busy_q, busy_d;

  logic        note_end;
  logic        in_alarm;
  logic        chime_ok;

`ifdef BUZZER_CLICK_EN
  localparam logic [23:0] CLICK_LAST = 24'(CLICK_TICKS - 1);
  assign chime_ok = (state_q == S_IDLE) || (state_q == S_CLICK);
`else
  // Click source is not built; keep its inputs visibly consumed.
  logic [17:0] unused_click;
  assign unused_click = {key_click, CLICK_DIV};
  assign chime_ok     = (state_q == S_IDLE);
`endif

  assign note_end = (tick_q == NOTE_LAST);
  assign in_alarm = (state_q == S_ALARM) || (state_q == S_ALARM_GAP);

  // Next-state logic: preemption first, then normal sequencing.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    beep_d  = beep_q;
    pass_d  = pass_q;
    idx_d   = idx_q;

    if (alarm_req && !in_alarm) begin
      state_d = S_ALARM;
      tick_d  = '0;
      beep_d  = '0;
      pass_d  = '0;
      idx_d   = '0;
    end else if (stop && in_alarm) begin
      state_d = S_IDLE;
      tick_d  = '0;
      beep_d  = '0;
      pass_d  = '0;
      idx_d   = '0;
    end else if (chime_req && chime_ok) begin
      state_d = S_CHIME_ON;
      tick_d  = '0;
      beep_d  = '0;
`ifdef BUZZER_CLICK_EN
    end else if (key_click && (state_q == S_IDLE)) begin
      state_d = S_CLICK;
      tick_d  = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tick_d = '0;
        end
`ifdef BUZZER_CLICK_EN
        S_CLICK: begin
          if (tick_q == CLICK_LAST) begin
            state_d = S_IDLE;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 24'd1;
          end
        end
`endif
        S_CHIME_ON: begin
          if (note_end) begin
            tick_d = '0;
            // Second beep ends the chime with no trailing gap.
            if (beep_q == 2'd1) begin
              state_d = S_IDLE;
              beep_d  = '0;
            end else begin
              state_d = S_CHIME_GAP;
              beep_d  = beep_q + 2'd1;
            end
          end else begin
            tick_d = tick_q + 24'd1;
          end
        end
        S_CHIME_GAP: begin
          if (note_end) begin
            state_d = S_CHIME_ON;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 24'd1;
          end
        end
        S_ALARM: begin
          if (note_end) begin
            tick_d = '0;
            if (idx_q == 6'd63) begin
              idx_d = '0;
              if ((pass_q + 4'd1) == REPEAT_N) begin
                state_d = S_IDLE;
                pass_d  = '0;
              end else begin
                state_d = S_ALARM_GAP;
                pass_d  = pass_q + 4'd1;
                beep_d  = '0;
              end
            end else begin
              idx_d = idx_q + 6'd1;
            end
          end else begin
            tick_d = tick_q + 24'd1;
          end
        end
        S_ALARM_GAP: begin
          // Gap is four note periods; counted as four tick wraps so the
          // 24-bit tick counter never has to hold 4*NOTE_TICKS.
          if (note_end) begin
            tick_d = '0;
            if (beep_q == 2'd3) begin
              state_d = S_ALARM;
              beep_d  = '0;
            end else begin
              beep_d = beep_q + 2'd1;
            end
          end else begin
            tick_d = tick_q + 24'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
          beep_d  = '0;
          pass_d  = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the current state; registered below so outputs lag
  // the state by one cycle.
  always_comb begin
    tone_en_d  = 1'b0;
    tone_div_d = '0;
    src_d      = 2'd0;
    busy_d     = (state_q != S_IDLE);
    case (state_q)
`ifdef BUZZER_CLICK_EN
      S_CLICK: begin
        tone_en_d  = 1'b1;
        tone_div_d = CLICK_DIV;
        src_d      = 2'd1;
      end
`endif
      S_CHIME_ON: begin
        tone_en_d  = 1'b1;
        tone_div_d = CHIME_DIV;
        src_d      = 2'd2;
      end
      S_CHIME_GAP: begin
        src_d = 2'd2;
      end
      S_ALARM: begin
        tone_en_d  = 1'b1;
        tone_div_d = song_div;
        src_d      = 2'd3;
      end
      S_ALARM_GAP: begin
        src_d = 2'd3;
      end
      default: begin
        src_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      beep_q     <= '0;
      pass_q     <= '0;
      idx_q      <= '0;
      tone_en_q  <= 1'b0;
      tone_div_q <= '0;
      src_q      <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      beep_q     <= beep_d;
      pass_q     <= pass_d;
      idx_q      <= idx_d;
      tone_en_q  <= tone_en_d;
      tone_div_q <= tone_div_d;
      src_q      <= src_d;
      busy_q     <= busy_d;
    end
  end

  assign song_idx  = idx_q;
  assign tone_en   = tone_en_q;
  assign tone_div  = tone_div_q;
  assign src       = src_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: doc/buzzer_sched.md
# buzzer_sched

Arbitrates and sequences the board's single square-wave buzzer between three requesters: alarm melody, hourly chime and key click. Drives the tone generator with an enable and a half-period divider, and steps a 64-entry melody ROM for the alarm. Sits between the clock/alarm comparison logic and the buzzer tone generator, so no requester drives the pin directly.

## Interface
- NOTE_TICKS, 6000000: clk cycles per melody note and per chime beep/gap (250 ms at 24 MHz); must be ≥2 and <2^24.
- CLICK_TICKS, 1200000: clk cycles of a key click (50 ms); must be ≥2 and <2^24.
- ALARM_REPEAT, 3: number of melody passes per alarm (1..15).
- CHIME_DIV, 17'd11466: tone_div used for chime beeps.
- CLICK_DIV, 17'd5454: tone_div used for key click.
- clk  in  1  system clock, 24 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- alarm_req  in  1  one-cycle pulse: alarm time reached.
- chime_req  in  1  one-cycle pulse: hour rollover.
- key_click  in  1  one-cycle pulse: debounced key press.
- stop  in  1  level or pulse: cancel a running alarm.
- song_div  in  17  half-period for song_idx, from combinational melody ROM.
- song_idx  out  6  melody ROM address.
- tone_en  out  1  tone generator enable; buzzer silent (pin high) when 0.
- tone_div  out  17  half-period count for tone generator.
- src  out  2  active source: 0 none, 1 click, 2 chime, 3 alarm.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CLICK, CHIME_ON, CHIME_GAP, ALARM, ALARM_GAP. One 24-bit tick counter `tick`, 2-bit chime beep counter, 4-bit pass counter.
- Priority alarm > chime > click. Higher source preempts lower immediately (tick cleared, counters reset). Request for a source of equal or lower priority than the active one is dropped, not queued; alarm_req during ALARM/ALARM_GAP is ignored.
- Same-cycle requests: highest wins, others dropped.
- CLICK: tone CLICK_DIV for CLICK_TICKS cycles → IDLE.
- Chime: CHIME_ON (CHIME_DIV, NOTE_TICKS) → CHIME_GAP (silent, NOTE_TICKS) → CHIME_ON; two beeps total; after second CHIME_ON → IDLE (no trailing gap).
- ALARM: song_idx 0..63, each held NOTE_TICKS cycles, tone_div = song_div. After idx 63: pass counter +1; if passes = ALARM_REPEAT → IDLE, else ALARM_GAP (silent, 4×NOTE_TICKS) → ALARM with song_idx = 0.
- stop high in ALARM or ALARM_GAP → IDLE next edge; ignored in other states.
- song_idx held at 0 outside ALARM.
- Reset: state IDLE, tick 0, counters 0, song_idx 0, tone_en 0, tone_div 0, src 0, busy 0.

## Timing
- Requests sampled on rising clk; state/song_idx update on that edge (cycle N+1 after pulse in cycle N).
- tone_en, tone_div, src, busy are registered from state and song_div: valid one cycle after state, i.e. 2 cycles after request pulse; likewise drop 1 cycle after state returns to IDLE.
- Durations exact: a note/beep/click/gap occupies exactly its tick count in state; tick wraps to 0 on the terminal cycle (tick = COUNT−1) while state/song_idx advance.
- song_div must be valid combinationally from song_idx in the same cycle; tone_div therefore lags song_idx by one cycle.
- Preemption or stop mid-note: no partial-note completion; new output visible 2 cycles after the event.
- rst_n asserted mid-operation: all outputs to reset values asynchronously; no resume after release.

## Configuration
- BUZZER_CLICK_EN defined: key_click source and CLICK state present as above.
- Undefined: key_click ignored, CLICK state and CLICK_DIV logic absent; src never 1.

## Test plan
Bench parameters NOTE_TICKS=4, CLICK_TICKS=2, ALARM_REPEAT=2, stub ROM song_div = 1000+idx.
- key_click pulse in IDLE → tone_en=1, tone_div=5454, src=1 for exactly 2 cycles starting 2 cycles after pulse; busy back to 0.
- chime_req → tone on 4, off 4, on 4 cycles at tone_div=11466, then IDLE; total busy 12 cycles.
- alarm_req → song_idx 0..63 each 4 cycles, tone_div=1000..1063; 16-cycle silent gap; second pass; IDLE after 2×256+16 cycles.
- key_click during chime → dropped, chime timing unchanged; alarm_req during chime CHIME_GAP → src=3, song_idx=0, chime abandoned.
- stop at song_idx=10 → IDLE next edge, tone_en=0 two cycles after stop; following alarm_req starts from pass 1, idx 0.
- rst_n low mid-alarm → tone_en=0, src=0, song_idx=0 immediately; simultaneous alarm_req+chime_req+key_click → alarm only.
